// File: rtl/rx.sv
// UART receiver: start bit, 8 data bits LSB first, parity, one stop bit.
// The received byte comes with a one-cycle strobe and parity/framing status.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the majority of three
// samples around its nominal sample point, and the FSM advances one cycle later.
module rx #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       odd,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int BIT_MAX  = CLK_FREQUENCY / BAUD_RATE - 1;
  localparam int HALF_MAX = BIT_MAX / 2;
`ifdef RX_MAJORITY_VOTE_EN
  // The timer has to reach T+1, so it needs room for one extra count.
  localparam int TW = $clog2(BIT_MAX + 2);
`else
  localparam int TW = $clog2(BIT_MAX + 1);
`endif
  localparam logic [TW-1:0] HALF_T = TW'(HALF_MAX);
  localparam logic [TW-1:0] BIT_T  = TW'(BIT_MAX);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          rx_sync;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          strobe_q, strobe_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [TW-1:0] term;
  logic          fire;
  logic          bit_val;

`ifdef RX_MAJORITY_VOTE_EN
  logic v0_q, v0_d, v1_q, v1_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  assign rx_sync = sync2_q;

  // Two-flop synchronizer; reset to the idle line level so no false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Sample-point timing: half a bit for the start check, a full bit afterwards.
  always_comb begin
    term = (state_q == S_START) ? HALF_T : BIT_T;
`ifdef RX_MAJORITY_VOTE_EN
    fire    = (timer_q == term + ONE_T);
    bit_val = maj3(v0_q, v1_q, rx_sync);
    v0_d    = (timer_q == term - ONE_T) ? rx_sync : v0_q;
    v1_d    = (timer_q == term) ? rx_sync : v1_q;
`else
    fire    = (timer_q == term);
    bit_val = rx_sync;
`endif
  end

  // Next-state logic: frame sequencing, bit assembly and status update.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + ONE_T;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_sync) state_d = S_START;
      end
      S_START: begin
        if (fire) begin
          timer_d = '0;
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          timer_d = '0;
          shift_d = {bit_val, shift_q[8:1]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd8) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fire) begin
          timer_d  = '0;
          dout_d   = shift_q[7:0];
          perr_d   = (^shift_q) ^ odd;
          ferr_d   = ~bit_val;
          strobe_d = 1'b1;
          state_d  = bit_val ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_sync) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and visible outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cnt_q    <= 4'd0;
      dout_q   <= 8'd0;
      strobe_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Shift register (and vote history) carry only data; the FSM qualifies them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef RX_MAJORITY_VOTE_EN
    v0_q    <= v0_d;
    v1_q    <= v1_d;
`endif
  end

  assign dout          = dout_q;
  assign data_strobe   = strobe_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx.sv
// Bench for the UART receiver: table-driven frames, hand-written corner
// sequences, then random frames checked against a behavioural model.
module tb_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       odd;
  logic [7:0] dout;
  logic       data_strobe;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  rx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .odd(odd), .dout(dout),
    .data_strobe(data_strobe), .parity_error(parity_error),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int BITC = 10;  // clocks per bit

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } obs_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       odd;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  obs_t obs_q[$];
  int   cyc = 0;
  int   last_start = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle the strobe is high; a stretched strobe shows up as two.
  always @(negedge clk) begin
    if (data_strobe) obs_q.push_back('{dout, parity_error, framing_error, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference serializer; glitch_slot flips one mid-slot cycle of that slot.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_slot);
    logic b;
    last_start = cyc;
    for (int slot = 0; slot < 11; slot++) begin
      if (slot == 0) b = 1'b0;
      else if (slot <= 8) b = d[slot-1];
      else if (slot == 9) b = p;
      else b = s;
      for (int j = 0; j < BITC; j++) begin
        rx_in = (slot == glitch_slot && j == 4) ? ~b : b;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input string nm, input logic [7:0] ed,
                             input logic epe, input logic efe);
    obs_t o;
    int   lat;
    chk({nm, " strobe count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      lat = o.c - last_start;
      chk({nm, " dout"}, o.d, ed);
      chk({nm, " parity_error"}, o.pe, epe);
      chk({nm, " framing_error"}, o.fe, efe);
      chk({nm, " latency in 106..109"}, (lat >= 106 && lat <= 109), 1);
    end
    obs_q.delete();
  endtask

  function automatic logic model_perr(input logic [7:0] d, input logic p, input logic o);
    return ((($countones(d) + int'(p) + int'(o)) % 2) == 1);
  endfunction

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; rx_in = 1'b1; odd = 1'b0;
    wait_cyc(3);
    chk("reset dout", dout, 8'h00);
    chk("reset strobe", data_strobe, 0);
    chk("reset parity_error", parity_error, 0);
    chk("reset framing_error", framing_error, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    wait_cyc(5);

    // Table frames; entries 3 and 4 run back-to-back with no idle gap.
    for (int i = 0; i < 5; i++) begin
      odd = vecs[i].odd;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, -1);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_perr,
                  vecs[i].exp_ferr);
    end
    wait_cyc(3);
    chk("busy low after table", busy, 0);

    // Framing error with the line held low afterwards.
    odd = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      wait_cyc(10);
      chk($sformatf("busy held in break %0d", k), busy, 1);
    end
    check_frame("framing", 8'h3C, 1'b0, 1'b1);
    rx_in = 1'b1;
    wait_cyc(5);
    chk("busy after break release", busy, 0);
    chk("no strobe after break", obs_q.size(), 0);

    // False start: two-cycle low glitch on the idle line.
    rx_in = 1'b0;
    wait_cyc(2);
    rx_in = 1'b1;
    wait_cyc(2);
    chk("false start busy", busy, 1);
    wait_cyc(6);
    chk("false start busy cleared", busy, 0);
    chk("false start no strobe", obs_q.size(), 0);
    chk("false start dout kept", dout, 8'h3C);
    chk("false start ferr kept", framing_error, 1);

    // Reset in the middle of data bit 3.
    last_start = cyc;
    rx_in = 1'b0; wait_cyc(BITC);
    rx_in = 1'b1; wait_cyc(BITC);
    rx_in = 1'b0; wait_cyc(BITC);
    rx_in = 1'b1; wait_cyc(BITC);
    rx_in = 1'b0; wait_cyc(5);
    rst = 1'b1; rx_in = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("midreset dout", dout, 8'h00);
    chk("midreset strobe", data_strobe, 0);
    chk("midreset parity_error", parity_error, 0);
    chk("midreset framing_error", framing_error, 0);
    chk("midreset busy", busy, 0);
    wait_cyc(20);
    chk("midreset no strobe", obs_q.size(), 0);
    send_frame(8'h7E, 1'b0, 1'b1, -1);
    check_frame("after reset 7E", 8'h7E, 1'b0, 1'b0);

`ifdef RX_MAJORITY_VOTE_EN
    // One-cycle glitch exactly at the sample point of data bit 3.
    odd = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 4);
    check_frame("vote glitch", 8'hA5, 1'b0, 1'b0);
`endif

    // Random frames against the behavioural model.
    begin
      logic       prev_stop = 1'b1;
      logic [7:0] d;
      logic       p, s, o;
      int         gap;
      for (int n = 0; n < 24; n++) begin
        d = 8'($urandom);
        p = 1'($urandom);
        o = 1'($urandom);
        s = ($urandom_range(0, 5) != 0);
        gap = prev_stop ? $urandom_range(0, 12) : $urandom_range(3, 12);
        rx_in = 1'b1;
        wait_cyc(gap);
        odd = o;
        send_frame(d, p, s, -1);
        check_frame($sformatf("rand%0d", n), d, model_perr(d, p, o), ~s);
        prev_stop = s;
      end
      rx_in = 1'b1;
      wait_cyc(5);
      chk("rand end busy", busy, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx.md
Name: rx

Overview:
- UART receiver, the counterpart to the team's serial transmitter.
- Deserialises a frame from the `rx_in` pin: start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Idle line is 1.
- Presents the byte with a one-cycle strobe and per-frame parity and framing status.
- Sits in the I/O system between the board RX pin and the UART peripheral registers.

Parameters:
- CLK_FREQUENCY, 100000000: system clock frequency in Hz.
- BAUD_RATE, 19200: bit rate in bits/s.
- Derived BIT_MAX = CLK_FREQUENCY/BAUD_RATE - 1. Derived HALF_MAX = BIT_MAX/2, integer division.
- Derived timer width = ceil(log2(BIT_MAX+1)).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line.
- odd  input  1  parity select: 0 = even, 1 = odd. Sampled at the parity check.
- dout  output  8  last received byte.
- data_strobe  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity status of the last frame.
- framing_error  output  1  stop-bit status of the last frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1 at a posedge):
  - dout=0, data_strobe=0, parity_error=0, framing_error=0, busy=0.
  - Synchronizer flops set to 1, timer=0, bit counter=0, state=IDLE.
  - Reset mid-frame aborts the frame with no strobe.
- Synchronizer: 2 flops on rx_in produce rx_sync. All decisions use rx_sync only.
- Baud timer: cleared on every state entry, increments each cycle in START/DATA/STOP. Terminal count is HALF_MAX in START and BIT_MAX in DATA/STOP.
- Bit counter: 4 bits, cleared on START to DATA, increments per DATA sample.
- IDLE:
  - busy=0.
  - rx_sync==0 goes to START.
- START:
  - busy=1.
  - At HALF_MAX: rx_sync==1 is a false start and returns to IDLE with no outputs changed. Otherwise go to DATA.
  - Sampling therefore occurs near mid-bit for all later bits.
- DATA:
  - At BIT_MAX, shift rx_sync into a 9-bit shift register from the MSB end (LSB-first arrival) and increment the bit counter.
  - After the 9th sample (8 data + parity) go to STOP.
- STOP: at BIT_MAX, sample the stop bit and update outputs in the same edge:
  - dout = data[7:0].
  - parity_error = (^data) ^ parity_bit ^ odd. Zero means correct: even total ones when odd=0, odd total when odd=1.
  - framing_error = ~stop_sample.
  - data_strobe=1 for exactly the next cycle.
  - If stop_sample==1 go to IDLE. Otherwise go to BREAK.
- BREAK:
  - busy=1.
  - Wait until rx_sync==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Output holding:
  - dout and the error flags hold until the next completed frame.
  - The strobe pulses even on parity or framing error.
- Back-to-back frames: a start edge arriving in the cycle IDLE is entered is accepted. There are no lost frames at full line rate.
- Latency: data_strobe rises 2 synchronizer cycles + (HALF_MAX+1) + 10*(BIT_MAX+1) cycles after the rx_in falling edge, ±1 cycle.
- Unused state encodings go to IDLE.

Optional Feature:
- RX_MAJORITY_VOTE_EN defined:
  - Each bit value (start check, data, parity, stop) is the majority of rx_sync at timer counts T-1, T and T+1 around the nominal sample point T.
  - State advance still occurs at T+1, so latency grows by 1 cycle.
  - Requires BIT_MAX >= 4.
- Not defined: single sample at T, as described above.

Test Plan:
All tests use CLK_FREQUENCY=1000, BAUD_RATE=100, so BIT_MAX=9 and HALF_MAX=4, and drive bits from a reference serializer.
- Even-parity frame: odd=0, send 0x41 with parity 0, stop 1 -> one data_strobe, dout=0x41, parity_error=0, framing_error=0, busy low afterwards.
- Parity error: odd=1, send 0xA5 with parity 0 (correct is 1) -> strobe, dout=0xA5, parity_error=1. Then send 0xA5 with parity 1 -> parity_error=0.
- Framing error:
  - Send 0x3C with stop=0 and hold the line low for 30 cycles -> strobe once, framing_error=1, busy stays 1 while low, no second strobe.
  - Release the line -> IDLE.
- False start: 2-cycle low glitch on idle line -> no strobe, busy returns 0 within 8 cycles, dout unchanged.
- Reset mid-frame: assert rst during the 4th data bit -> all outputs 0 next cycle, no strobe. Then a clean 0x7E frame is received correctly.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two strobes, dout 0x00 then 0xFF, no errors. With RX_MAJORITY_VOTE_EN, a 1-cycle glitch at the sample point of data bit 3 does not corrupt the byte.
